// File: rtl/fpu_resp_buffer.sv
// In-order landing buffer for FPU results. It issues credits so that every in-flight result has a guaranteed slot, and it discards results that belong to flushed requests.
// Latency: 1 cycle from response to wb_valid_o, with no bypass. Backpressure: wb_ready_i stalls the head entry, and the FPU side is throttled only through credits.
module fpu_resp_buffer #(
    parameter int DEPTH         = 4,
    parameter int TRANS_ID_BITS = 3,
    parameter int FLEN          = 64,
    parameter int CW            = $clog2(DEPTH+1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_fire_i,
    output logic                     credit_avail_o,
    input  logic                     fpu_valid_i,
    input  logic [TRANS_ID_BITS-1:0] fpu_trans_id_i,
    input  logic [FLEN-1:0]          fpu_result_i,
    input  logic [4:0]               fpu_fflags_i,
    input  logic                     fpu_exc_valid_i,
    input  logic                     flush_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [FLEN-1:0]          wb_result_o,
    output logic [4:0]               wb_fflags_o,
    output logic                     wb_exc_valid_o,
    output logic [CW-1:0]            count_o,
    output logic                     err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [FLEN-1:0]          result;
        logic [4:0]               fflags;
        logic                     exc_valid;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]   occ, inflight, drop, occ_n, inflight_n, drop_n;
    logic [SW-1:0]   committed;
    logic            err_n;
    logic            issue_ok, resp_known, resp_drop, resp_wr, pop;

    // Credit is derived from registered state only, so the request side never sees a combinational loop.
    assign committed      = SW'(inflight) + SW'(drop) + SW'(occ);
    assign credit_avail_o = (drop == '0) && (committed < SW'(DEPTH));

    assign head           = mem[rd_ptr];
    assign wb_valid_o     = (occ != '0);
    assign wb_trans_id_o  = head.trans_id;
    assign wb_result_o    = head.result;
    assign wb_fflags_o    = head.fflags;
    assign wb_exc_valid_o = head.exc_valid;
    assign count_o        = occ;

    always_comb begin
        issue_ok   = issue_fire_i && credit_avail_o;
        resp_known = (drop != '0) || (inflight != '0);
        resp_drop  = fpu_valid_i && (drop != '0);
        resp_wr    = fpu_valid_i && (drop == '0) && (inflight != '0);
        pop        = wb_valid_o && wb_ready_i;

        occ_n      = occ;
        inflight_n = inflight;
        drop_n     = drop;
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        err_n      = err_o | (issue_fire_i && !credit_avail_o) | (fpu_valid_i && !resp_known);

        if (flush_i) begin
            // Everything outstanding, including this cycle's issue, becomes a result to discard.
            occ_n      = '0;
            wr_ptr_n   = '0;
            rd_ptr_n   = '0;
            inflight_n = '0;
            drop_n     = drop + inflight + CW'(issue_ok) - CW'(fpu_valid_i && resp_known);
        end else begin
            inflight_n = inflight + CW'(issue_ok) - CW'(resp_wr);
            drop_n     = drop - CW'(resp_drop);
            occ_n      = occ + CW'(resp_wr) - CW'(pop);
            wr_ptr_n   = wr_ptr + PW'(resp_wr);
            rd_ptr_n   = rd_ptr + PW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ      <= '0;
            inflight <= '0;
            drop     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_o    <= 1'b0;
        end else begin
            occ      <= occ_n;
            inflight <= inflight_n;
            drop     <= drop_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            err_o    <= err_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (resp_wr && !flush_i) begin
            mem[wr_ptr] <= '{trans_id:  fpu_trans_id_i,
                             result:    fpu_result_i,
                             fflags:    fpu_fflags_i,
                             exc_valid: fpu_exc_valid_i};
        end
    end
endmodule

// File: tb/tb_fpu_resp_buffer.sv
module tb_fpu_resp_buffer;
    localparam int DEPTH = 4;
    localparam int TIDB  = 3;
    localparam int FLEN  = 64;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            issue_fire_i, credit_avail_o;
    logic            fpu_valid_i;
    logic [TIDB-1:0] fpu_trans_id_i;
    logic [FLEN-1:0] fpu_result_i;
    logic [4:0]      fpu_fflags_i;
    logic            fpu_exc_valid_i, flush_i;
    logic            wb_valid_o, wb_ready_i;
    logic [TIDB-1:0] wb_trans_id_o;
    logic [FLEN-1:0] wb_result_o;
    logic [4:0]      wb_fflags_o;
    logic            wb_exc_valid_o;
    logic [CW-1:0]   count_o;
    logic            err_o;

    int checks   = 0;
    int failures = 0;

    fpu_resp_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(TIDB), .FLEN(FLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_fire_i(issue_fire_i), .credit_avail_o(credit_avail_o),
        .fpu_valid_i(fpu_valid_i), .fpu_trans_id_i(fpu_trans_id_i),
        .fpu_result_i(fpu_result_i), .fpu_fflags_i(fpu_fflags_i),
        .fpu_exc_valid_i(fpu_exc_valid_i), .flush_i(flush_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
        .wb_fflags_o(wb_fflags_o), .wb_exc_valid_o(wb_exc_valid_o),
        .count_o(count_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_fire_i = 0; fpu_valid_i = 0; fpu_trans_id_i = '0; fpu_result_i = '0;
        fpu_fflags_i = '0; fpu_exc_valid_i = 0; flush_i = 0; wb_ready_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        cyc(); cyc();
        rst_ni = 1;
        cyc();
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            issue_fire_i = 1; cyc();
        end
        issue_fire_i = 0;
    endtask

    task automatic respond(input logic [TIDB-1:0] tid);
        fpu_valid_i = 1; fpu_trans_id_i = tid; fpu_result_i = 64'hA000_0000_0000_0000 | FLEN'(tid);
        cyc();
        fpu_valid_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        cyc();
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid_o); end
        checks++; if (credit_avail_o !== 1'b1) begin failures++; $display("FAIL reset_credit got=%0b exp=1", credit_avail_o); end
        checks++; if (count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        checks++; if ({wb_trans_id_o, wb_result_o, wb_fflags_o, wb_exc_valid_o} !== '0) begin
            failures++; $display("FAIL reset_payload got=%0h/%0h/%0h/%0b exp=0", wb_trans_id_o, wb_result_o, wb_fflags_o, wb_exc_valid_o);
        end
        rst_ni = 1;
        cyc();
    endtask

    task automatic test_single();
        issue_n(1);
        checks++; if (credit_avail_o !== 1'b1) begin failures++; $display("FAIL single_credit got=%0b exp=1", credit_avail_o); end
        wb_ready_i = 1;
        fpu_valid_i = 1; fpu_trans_id_i = 3; fpu_result_i = 64'h3FF0000000000000;
        fpu_fflags_i = 5'h01; fpu_exc_valid_i = 1;
        checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", wb_valid_o); end
        cyc();
        fpu_valid_i = 0; fpu_fflags_i = '0; fpu_exc_valid_i = 0;
        checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", wb_valid_o); end
        checks++; if (wb_trans_id_o !== 3'd3) begin failures++; $display("FAIL single_tid got=%0d exp=3", wb_trans_id_o); end
        checks++; if (wb_result_o !== 64'h3FF0000000000000) begin failures++; $display("FAIL single_result got=%0h exp=3ff0000000000000", wb_result_o); end
        checks++; if (wb_fflags_o !== 5'h01 || wb_exc_valid_o !== 1'b1) begin
            failures++; $display("FAIL single_flags got=%0h/%0b exp=1/1", wb_fflags_o, wb_exc_valid_o);
        end
        checks++; if (count_o !== 1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
        cyc();
        wb_ready_i = 0;
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 0) begin
            failures++; $display("FAIL single_drained got=%0b/%0d exp=0/0", wb_valid_o, count_o);
        end
    endtask

    task automatic test_fill_backpressure();
        wb_ready_i = 0;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (credit_avail_o !== 1'b1) begin failures++; $display("FAIL fill_credit_%0d got=%0b exp=1", i, credit_avail_o); end
            issue_fire_i = 1; cyc();
        end
        issue_fire_i = 0;
        checks++; if (credit_avail_o !== 1'b0) begin failures++; $display("FAIL fill_credit_zero got=%0b exp=0", credit_avail_o); end
        for (int i = 0; i < DEPTH; i++) respond(TIDB'(i + 4));
        checks++; if (count_o !== 4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        checks++; if (credit_avail_o !== 1'b0) begin failures++; $display("FAIL fill_full_credit got=%0b exp=0", credit_avail_o); end
        wb_ready_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== TIDB'(i + 4)) begin
                failures++; $display("FAIL drain_order_%0d got=%0b/%0d exp=1/%0d", i, wb_valid_o, wb_trans_id_o, i + 4);
            end
            cyc();
            if (i == 0) begin
                checks++; if (credit_avail_o !== 1'b1) begin failures++; $display("FAIL drain_credit_back got=%0b exp=1", credit_avail_o); end
            end
        end
        wb_ready_i = 0;
        checks++; if (count_o !== 0 || wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL drain_empty got=%0d/%0b exp=0/0", count_o, wb_valid_o);
        end
    endtask

    task automatic test_flush();
        issue_n(3);
        respond(3'd1);
        flush_i = 1; cyc(); flush_i = 0;
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 0) begin
            failures++; $display("FAIL flush_clear got=%0b/%0d exp=0/0", wb_valid_o, count_o);
        end
        checks++; if (credit_avail_o !== 1'b0) begin failures++; $display("FAIL flush_credit got=%0b exp=0", credit_avail_o); end
        respond(3'd2);
        checks++; if (credit_avail_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_drop1 got=%0b/%0b exp=0/0", credit_avail_o, wb_valid_o);
        end
        respond(3'd3);
        checks++; if (credit_avail_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_drop2 got=%0b/%0b exp=1/0", credit_avail_o, wb_valid_o);
        end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL flush_no_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_back_to_back();
        wb_ready_i = 0;
        issue_n(3);
        respond(3'd1);
        respond(3'd2);
        checks++; if (count_o !== 2) begin failures++; $display("FAIL simul_pre_count got=%0d exp=2", count_o); end
        issue_fire_i = 1; fpu_valid_i = 1; fpu_trans_id_i = 3'd3; wb_ready_i = 1;
        cyc();
        issue_fire_i = 0; wb_ready_i = 0;
        checks++; if (count_o !== 2) begin failures++; $display("FAIL simul_count got=%0d exp=2", count_o); end
        checks++; if (wb_trans_id_o !== 3'd2) begin failures++; $display("FAIL simul_head got=%0d exp=2", wb_trans_id_o); end
        // inflight stays 1: occ 2 + inflight 1 = 3 leaves a credit
        checks++; if (credit_avail_o !== 1'b1) begin failures++; $display("FAIL simul_credit got=%0b exp=1", credit_avail_o); end
        fpu_trans_id_i = 3'd4; cyc(); fpu_valid_i = 0;
        checks++; if (count_o !== 3) begin failures++; $display("FAIL simul_count3 got=%0d exp=3", count_o); end
        wb_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wb_valid_o !== 1'b1 || wb_trans_id_o !== TIDB'(i + 2)) begin
                failures++; $display("FAIL simul_order_%0d got=%0b/%0d exp=1/%0d", i, wb_valid_o, wb_trans_id_o, i + 2);
            end
            cyc();
        end
        wb_ready_i = 0;
        checks++; if (count_o !== 0 || credit_avail_o !== 1'b1) begin
            failures++; $display("FAIL simul_end got=%0d/%0b exp=0/1", count_o, credit_avail_o);
        end
    endtask

    task automatic test_protocol_errors();
        do_reset();
        respond(3'd5);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL unsolicited_err got=%0b exp=1", err_o); end
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 0) begin
            failures++; $display("FAIL unsolicited_stored got=%0b/%0d exp=0/0", wb_valid_o, count_o);
        end
        do_reset();
        issue_n(DEPTH);
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL overissue_pre_err got=%0b exp=0", err_o); end
        issue_n(1);
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL overissue_err got=%0b exp=1", err_o); end
        for (int i = 0; i < DEPTH; i++) respond(TIDB'(i));
        checks++; if (count_o !== 4) begin failures++; $display("FAIL overissue_count got=%0d exp=4", count_o); end
        wb_ready_i = 1;
        cyc(); cyc(); cyc(); cyc();
        wb_ready_i = 0;
        // if the rejected issue had counted, a phantom in-flight request would still hold a credit
        checks++; if (credit_avail_o !== 1'b1 || count_o !== 0) begin
            failures++; $display("FAIL overissue_unchanged got=%0b/%0d exp=1/0", credit_avail_o, count_o);
        end
    endtask

    task automatic test_async_reset();
        issue_n(2);
        respond(3'd6);
        respond(3'd7);
        checks++; if (count_o !== 2 || wb_valid_o !== 1'b1) begin
            failures++; $display("FAIL areset_pre got=%0d/%0b exp=2/1", count_o, wb_valid_o);
        end
        #2 rst_ni = 0;
        #1;
        checks++; if (wb_valid_o !== 1'b0 || count_o !== 0) begin
            failures++; $display("FAIL areset_state got=%0b/%0d exp=0/0", wb_valid_o, count_o);
        end
        checks++; if (credit_avail_o !== 1'b1 || err_o !== 1'b0) begin
            failures++; $display("FAIL areset_flags got=%0b/%0b exp=1/0", credit_avail_o, err_o);
        end
        checks++; if ({wb_trans_id_o, wb_result_o, wb_fflags_o, wb_exc_valid_o} !== '0) begin
            failures++; $display("FAIL areset_payload got=%0h/%0h exp=0/0", wb_trans_id_o, wb_result_o);
        end
        cyc();
        rst_ni = 1;
        cyc();
    endtask

    initial begin
        rst_ni = 0;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_backpressure();
        test_flush();
        test_back_to_back();
        test_protocol_errors();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
